// File: rtl/add_accumulator_pkg.sv
// add_acc_pkg: shared types and constants for the add_accumulator block.
//   state_t        - control FSM states
//   ACC_WIDTH      - default accumulator / adder width
//   SETTLE_DEFAULT - default number of cycles the adder is given to ripple
//   TIMER_W        - width of the settle counter
package add_acc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int ACC_WIDTH      = 16;
  localparam int SETTLE_DEFAULT = 2;
  localparam int TIMER_W        = 4;

endpackage

// File: rtl/add_accumulator_if.sv
// add_accumulator_if: groups the board-side controls and the adder-side
// operand/result signals of the accumulator stage.
//   Run, ClearA, S      - board controls and switch operand
//   Sum_in, CO_in       - results coming back from the ripple adder
//   A_out, B_out        - operands sent to the ripple adder
//   CO_flag, Busy, Done - status back to the board
// Modports:
//   master - the environment (board controls plus the adder)
//   slave  - the accumulator stage itself
interface add_accumulator_if #(
  parameter int WIDTH = 16
);

  logic             Run;
  logic             ClearA;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Sum_in;
  logic             CO_in;
  logic [WIDTH-1:0] A_out;
  logic [WIDTH-1:0] B_out;
  logic             CO_flag;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, ClearA, S, Sum_in, CO_in,
    input  A_out, B_out, CO_flag, Busy, Done
  );

  modport slave (
    input  Run, ClearA, S, Sum_in, CO_in,
    output A_out, B_out, CO_flag, Busy, Done
  );

endinterface

// File: rtl/add_accumulator_settle_timer.sv
// settle_timer: small counter that measures how long the adder operands
// have been stable.
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - forces the count to zero (has priority over enable)
//   enable     - advances the count by one
//   expired    - count has reached SETTLE_CYCLES-1
module settle_timer
  import add_acc_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(SETTLE_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/ripple_adder.sv
// ripple_adder: plain WIDTH-bit ripple-carry adder with zero carry-in.
//   A, B - operands
//   Sum  - A + B modulo 2^WIDTH
//   CO   - carry out of the top bit
module ripple_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             CO
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign CO = carry[WIDTH];

endmodule

// File: rtl/add_accumulator.sv
// add_accumulator: sequential accumulator stage wrapped around an external
// ripple adder. The accumulator feeds adder operand A and a register loaded
// from the switches feeds operand B. After a fixed settle window the adder
// result is captured back into the accumulator. A Run press yields exactly
// one addition no matter how long Run stays high.
//   Clk     - system clock, rising edge
//   Reset_n - asynchronous active-low reset
//   bus     - slave side of add_accumulator_if (controls, operands, status)
module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int WIDTH         = ACC_WIDTH,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  add_accumulator_if.slave   bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             co_q,    co_d;
  logic             done_q,  done_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // The counter is held at zero while idle, so it starts from zero on the
  // first SETTLE cycle without a separate load.
  assign timer_clear  = (state_q == IDLE);
  assign timer_enable = (state_q == SETTLE);

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    co_d    = co_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Clear wins over Run; a still-high Run starts the add next cycle.
        if (bus.ClearA) begin
          acc_d = '0;
          co_d  = 1'b0;
        end else if (bus.Run) begin
          b_d     = bus.S;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_expired) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        acc_d   = bus.Sum_in;
        co_d    = bus.CO_in;
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // Wait for Run to drop so a held button cannot trigger a second add.
        if (!bus.Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      co_q    <= co_d;
      done_q  <= done_d;
    end
  end

  assign bus.A_out   = acc_q;
  assign bus.B_out   = b_q;
  assign bus.CO_flag = co_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = (state_q == SETTLE) || (state_q == CAPTURE);

endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: directed bench for add_accumulator with a ripple_adder
// closing the loop between A_out/B_out and Sum_in/CO_in.
module tb_add_accumulator;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errs;

  add_accumulator_if #(.WIDTH(16)) bus ();

  add_accumulator #(
    .WIDTH         (16),
    .SETTLE_CYCLES (2)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  ripple_adder #(.WIDTH(16)) u_adder (
    .A   (bus.A_out),
    .B   (bus.B_out),
    .Sum (bus.Sum_in),
    .CO  (bus.CO_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Run pulse; checks operand load, busy window, result and Done pulse.
  task automatic run_add(input string tag, input logic [15:0] s,
                         input logic [15:0] exp_a, input logic exp_co);
    bus.S   = s;
    bus.Run = 1'b1;
    tick();                                  // e0
    bus.Run = 1'b0;
    check_val({tag, "_b"}, 32'(bus.B_out), 32'(s));
    check_val({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    tick();                                  // e1
    tick();                                  // e2
    check_val({tag, "_done_early"}, 32'(bus.Done), 32'd0);
    tick();                                  // e3: capture
    check_val({tag, "_a"}, 32'(bus.A_out), 32'(exp_a));
    check_val({tag, "_co"}, 32'(bus.CO_flag), 32'(exp_co));
    check_val({tag, "_done"}, 32'(bus.Done), 32'd1);
    tick();                                  // e4
    check_val({tag, "_done_off"}, 32'(bus.Done), 32'd0);
    check_val({tag, "_idle"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int pulses;
    n_checks   = 0;
    n_errs     = 0;
    rst_n      = 1'b0;
    bus.Run    = 1'b0;
    bus.ClearA = 1'b0;
    bus.S      = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("rst_a",    32'(bus.A_out),   32'h0000);
    check_val("rst_b",    32'(bus.B_out),   32'h0000);
    check_val("rst_co",   32'(bus.CO_flag), 32'd0);
    check_val("rst_busy", 32'(bus.Busy),    32'd0);
    check_val("rst_done", 32'(bus.Done),    32'd0);

    // Two adds, then wrap-around with carry, then carry cleared again.
    run_add("add1", 16'h3333, 16'h3333, 1'b0);
    run_add("add2", 16'h4444, 16'h7777, 1'b0);
    check_val("b_hold", 32'(bus.B_out), 32'h4444);
    run_add("wrap", 16'h9000, 16'h0777, 1'b1);
    run_add("post_wrap", 16'h0001, 16'h0778, 1'b0);

    // Clear back to zero.
    bus.ClearA = 1'b1;
    tick();
    bus.ClearA = 1'b0;
    check_val("clr_a", 32'(bus.A_out), 32'h0000);

    // Held Run: exactly one add.
    bus.S   = 16'h1111;
    bus.Run = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.Done) pulses++;
    end
    check_val("held_pulses", 32'(pulses), 32'd1);
    check_val("held_a", 32'(bus.A_out), 32'h1111);
    check_val("held_busy", 32'(bus.Busy), 32'd0);
    bus.Run = 1'b0;
    tick();

    // ClearA and Run together: clear first, then add sees zero.
    bus.S      = 16'h2222;
    bus.ClearA = 1'b1;
    bus.Run    = 1'b1;
    tick();
    bus.ClearA = 1'b0;
    check_val("prio_clr_a", 32'(bus.A_out), 32'h0000);
    check_val("prio_clr_busy", 32'(bus.Busy), 32'd0);
    tick();                                  // e0
    tick();                                  // e1
    tick();                                  // e2
    check_val("prio_mid_a", 32'(bus.A_out), 32'h0000);
    tick();                                  // e3
    check_val("prio_a", 32'(bus.A_out), 32'h2222);
    bus.Run = 1'b0;
    tick();

    // Reach 0x5000 with carry set, then reset mid-SETTLE.
    bus.ClearA = 1'b1;
    tick();
    bus.ClearA = 1'b0;
    run_add("pre1", 16'hD000, 16'hD000, 1'b0);
    run_add("pre2", 16'h8000, 16'h5000, 1'b1);
    bus.S   = 16'h1234;
    bus.Run = 1'b1;
    tick();                                  // e0
    bus.Run = 1'b0;
    tick();                                  // e1, in SETTLE
    check_val("mid_busy_pre", 32'(bus.Busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_a",    32'(bus.A_out),   32'h0000);
    check_val("mid_b",    32'(bus.B_out),   32'h0000);
    check_val("mid_co",   32'(bus.CO_flag), 32'd0);
    check_val("mid_busy", 32'(bus.Busy),    32'd0);
    check_val("mid_done", 32'(bus.Done),    32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Done) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.Done) pulses++;
    end
    check_val("mid_pulses", 32'(pulses), 32'd0);
    check_val("mid_after_a", 32'(bus.A_out), 32'h0000);
    check_val("mid_after_busy", 32'(bus.Busy), 32'd0);
    run_add("recover", 16'h0001, 16'h0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
